ps2_scan_sequencer: RTL and testbench
=====================================

PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning clk100MHz cycles without a PS/2 clock fall before a partial frame is abandoned (2 ms at 100 MHz).
REQ-002 SHALL have port clk100MHz  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port resetN  input  1  synchronous, active-low reset.
REQ-004 SHALL have port clkIn  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-005 SHALL have port dIn  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-006 SHALL have port keyCode  output  8  last completed make/break scan code.
REQ-007 SHALL have port keyExt  output  1  keyCode was preceded by the E0 prefix.
REQ-008 SHALL have port keyBreak  output  1  keyCode was preceded by the F0 prefix (key release).
REQ-009 SHALL have port keyValid  output  1  one-cycle pulse; keyCode/keyExt/keyBreak are updated in this cycle.
REQ-010 SHALL have port parityErr  output  1  one-cycle pulse on an odd-parity failure.
REQ-011 SHALL have port frameErr  output  1  one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-012 SHALL pass clkIn and dIn each through a 2-flop synchronizer, plus a third clkIn flop; fall = stage3 & ~stage2.
REQ-013 SHALL sample synchronized dIn only in cycles where fall=1.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on fall with dIn=0 (start bit), go to DATA with bitCnt=0; on fall with dIn=1, stay in IDLE with no error pulse.
REQ-016 DATA: on each fall, shift dIn into bit 7 of an 8-bit shift register (LSB first) and increment bitCnt; after the 8th bit, go to PARITY.
REQ-017 PARITY: on fall, capture the parity bit; the frame is good when data bits plus parity bit contain an odd number of ones; go to STOP.
REQ-018 STOP: on fall, return to IDLE and evaluate the frame in this order: stop bit=0 -> frameErr; else bad parity -> parityErr; else byte processing (REQ-019..021).
REQ-019 Byte 0xE0 SHALL set the ext flag, with no keyValid.
REQ-020 Byte 0xF0 SHALL set the brk flag, with no keyValid.
REQ-021 Any other byte SHALL load keyCode=byte, keyExt=ext, and keyBreak=brk, pulse keyValid, then clear both flags.
REQ-022 Any parityErr or frameErr SHALL clear the ext and brk flags and leave keyCode/keyExt/keyBreak unchanged.
REQ-023 Latency: keyValid/parityErr/frameErr SHALL assert in the cycle after the cycle in which the stop-bit fall is detected.
REQ-024 A timeout counter SHALL reset to 0 on every fall and in IDLE, and increment otherwise; when it reaches TIMEOUT_CYCLES in a non-IDLE state, the FSM goes to IDLE, pulses frameErr, and clears the flags.
REQ-025 If a fall and a timeout occur in the same cycle, the fall SHALL take priority and the timeout is ignored.
REQ-026 The timeout counter SHALL saturate and never wrap; its width is clog2(TIMEOUT_CYCLES+1).
REQ-027 keyValid, parityErr, and frameErr SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per event.

Reset
REQ-028 While resetN=0 at a clock edge: FSM=IDLE, bitCnt=0, shift register=0x00, flags=0, timeout counter=0, all synchronizer flops=1 (PS/2 idle level).
REQ-029 While resetN=0 at a clock edge: keyCode=0x00, keyExt=0, keyBreak=0, keyValid=0, parityErr=0, frameErr=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; the first start bit after resetN=1 begins a new frame.

Structure
REQ-031 A shared package ps2_pkg SHALL hold the FSM state typedef and the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
REQ-032 The synchronizer and fall detector SHALL be a sub-module ps2_edge_sync (ports: clk100MHz, resetN, clkIn, dIn, fall, dSync).
REQ-033 All outputs SHALL be driven directly from flops.

Verification
REQ-034 Frame 0x1C, good parity and stop bit, PS/2 clock at 12.5 kHz -> one keyValid, keyCode=0x1C, keyExt=0, keyBreak=0.
REQ-035 Frames F0, 1C -> a single keyValid with keyCode=0x1C, keyBreak=1, keyExt=0; no pulse after the F0 frame.
REQ-036 Frames E0, F0, 75 -> a single keyValid with keyCode=0x75, keyExt=1, keyBreak=1; the next frame 0x29 -> keyExt=0, keyBreak=0.
REQ-037 Frame E0, then 0x1C with the parity bit inverted -> parityErr pulse, no keyValid; the next good 0x1C -> keyExt=0.
REQ-038 Start bit plus 5 data bits, then clkIn held high for TIMEOUT_CYCLES -> frameErr pulse exactly TIMEOUT_CYCLES cycles after the last fall; a following good 0x1C frame is decoded correctly.
REQ-039 resetN pulsed low for 1 cycle after the 4th data bit -> no pulses, outputs at reset values; the next full frame 0x5A -> keyValid with keyCode=0x5A.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 scan-code receiver: FSM state encoding,
//   scan-code prefix bytes and the frame parity helper.
package ps2_pkg;

   typedef logic [1:0] ps2_state_t;

   localparam ps2_state_t ST_IDLE   = 2'd0;
   localparam ps2_state_t ST_DATA   = 2'd1;
   localparam ps2_state_t ST_PARITY = 2'd2;
   localparam ps2_state_t ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync
//   Brings the asynchronous PS/2 clock and data lines into the clk100MHz
//   domain and flags falling edges of the PS/2 clock.
//   clk100MHz : system clock (rising edge)
//   resetN    : synchronous active-low reset; all flops go to the PS/2 idle level 1
//   clkIn     : raw PS/2 clock
//   dIn       : raw PS/2 data
//   fall      : one-cycle strobe on a synchronized PS/2 clock falling edge
//   dSync     : synchronized PS/2 data
module ps2_edge_sync (
   input  logic clk100MHz,
   input  logic resetN,
   input  logic clkIn,
   input  logic dIn,
   output logic fall,
   output logic dSync
);

   logic r_clk1, r_clk2, r_clk3;
   logic r_d1, r_d2;

   always_ff @(posedge clk100MHz) begin
      if (!resetN) begin
         r_clk1 <= 1'b1;
         r_clk2 <= 1'b1;
         r_clk3 <= 1'b1;
         r_d1   <= 1'b1;
         r_d2   <= 1'b1;
      end else begin
         r_clk1 <= clkIn;
         r_clk2 <= r_clk1;
         r_clk3 <= r_clk2;
         r_d1   <= dIn;
         r_d2   <= r_d1;
      end
   end

   assign fall  = r_clk3 & ~r_clk2;
   assign dSync = r_d2;

endmodule

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Receives PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop)
//   and folds E0/F0 prefixes into extended/break flags on the next scan code.
//   clk100MHz : system clock (rising edge)
//   resetN    : synchronous active-low reset
//   clkIn/dIn : raw asynchronous PS/2 clock and data
//   keyCode   : last completed make/break scan code
//   keyExt    : keyCode was preceded by E0
//   keyBreak  : keyCode was preceded by F0
//   keyValid  : one-cycle pulse when keyCode/keyExt/keyBreak update
//   parityErr : one-cycle pulse on a parity failure
//   frameErr  : one-cycle pulse on a bad stop bit or an inter-edge timeout
module ps2_scan_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic       clk100MHz,
   input  logic       resetN,
   input  logic       clkIn,
   input  logic       dIn,
   output logic [7:0] keyCode,
   output logic       keyExt,
   output logic       keyBreak,
   output logic       keyValid,
   output logic       parityErr,
   output logic       frameErr
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic w_fall, w_dsync, w_tmo_hit;

   ps2_state_t    r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic          r_ext, r_brk;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_key_code;
   logic          r_key_ext, r_key_brk;
   logic          r_key_valid, r_parity_err, r_frame_err;

   ps2_edge_sync u_sync (
      .clk100MHz (clk100MHz),
      .resetN    (resetN),
      .clkIn     (clkIn),
      .dIn       (dIn),
      .fall      (w_fall),
      .dSync     (w_dsync)
   );

   // Fires on the cycle whose increment takes the counter to TIMEOUT_CYCLES,
   // so the FSM leaves the frame on the same edge the count is reached.
   assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TMO_LAST);

   always_ff @(posedge clk100MHz) begin
      if (!resetN) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_tmo        <= '0;
         r_key_code   <= '0;
         r_key_ext    <= 1'b0;
         r_key_brk    <= 1'b0;
         r_key_valid  <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_key_valid  <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;

         if (w_fall || (r_state == ST_IDLE))
            r_tmo <= '0;
         else if (r_tmo != TMO_MAX)
            r_tmo <= r_tmo + 1'b1;

         // A PS/2 clock fall always wins over a simultaneous timeout
         if (w_fall) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_dsync) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {w_dsync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= w_dsync;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (!w_dsync) begin
                     r_frame_err <= 1'b1;
                     r_ext       <= 1'b0;
                     r_brk       <= 1'b0;
                  end else if (!ps2_parity_ok(r_shift, r_parity)) begin
                     r_parity_err <= 1'b1;
                     r_ext        <= 1'b0;
                     r_brk        <= 1'b0;
                  end else if (r_shift == PS2_EXT) begin
                     r_ext <= 1'b1;
                  end else if (r_shift == PS2_BRK) begin
                     r_brk <= 1'b1;
                  end else begin
                     r_key_code  <= r_shift;
                     r_key_ext   <= r_ext;
                     r_key_brk   <= r_brk;
                     r_key_valid <= 1'b1;
                     r_ext       <= 1'b0;
                     r_brk       <= 1'b0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (w_tmo_hit) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
         end
      end
   end

   assign keyCode   = r_key_code;
   assign keyExt    = r_key_ext;
   assign keyBreak  = r_key_brk;
   assign keyValid  = r_key_valid;
   assign parityErr = r_parity_err;
   assign frameErr  = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer
//   Self-checking bench: frames are driven on clkIn/dIn, a protocol model
//   pushes the expected event per frame, and a monitor pops and compares
//   whenever the DUT pulses keyValid, parityErr or frameErr.
//   PS/2 clock is scaled to an 80-cycle period to keep the run short.
`timescale 1ns/1ps
module tb_ps2_scan_sequencer;

   localparam int unsigned TMO  = 500;
   localparam int unsigned HALF = 40;

   localparam int EV_VALID  = 0;
   localparam int EV_PARITY = 1;
   localparam int EV_FRAME  = 2;

   logic       clk    = 1'b0;
   logic       resetN = 1'b0;
   logic       clkIn  = 1'b1;
   logic       dIn    = 1'b1;
   logic [7:0] keyCode;
   logic       keyExt, keyBreak, keyValid, parityErr, frameErr;

   typedef struct {
      int          kind;
      logic [7:0]  code;
      logic        ext;
      logic        brk;
      int unsigned at;
   } ev_t;

   ev_t         q[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned t_fall = 0;
   logic        m_ext = 1'b0, m_brk = 1'b0;
   logic [7:0]  m_code = 8'h00;
   logic        m_kext = 1'b0, m_kbrk = 1'b0;
   logic        prev_any = 1'b0;

   ps2_scan_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk100MHz (clk),
      .resetN    (resetN),
      .clkIn     (clkIn),
      .dIn       (dIn),
      .keyCode   (keyCode),
      .keyExt    (keyExt),
      .keyBreak  (keyBreak),
      .keyValid  (keyValid),
      .parityErr (parityErr),
      .frameErr  (frameErr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int unsigned at);
      ev_t e;
      e.kind = kind;
      e.code = m_code;
      e.ext  = m_kext;
      e.brk  = m_kbrk;
      e.at   = at;
      q.push_back(e);
   endtask

   // One PS/2 bit: data settles half a period before the falling clock edge
   task automatic ps2_bit(input logic b);
      @(negedge clk);
      dIn = b;
      repeat (HALF) @(negedge clk);
      clkIn  = 1'b0;
      t_fall = cyc;
      repeat (HALF) @(negedge clk);
      clkIn = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic p;
      p = ~^b;
      if (bad_par) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      if (bad_stop) begin
         push_ev(EV_FRAME, 0);
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (bad_par) begin
         push_ev(EV_PARITY, 0);
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         m_code = b; m_kext = m_ext; m_kbrk = m_brk;
         push_ev(EV_VALID, 0);
         m_ext = 1'b0; m_brk = 1'b0;
      end
      ps2_bit(~bad_stop);
      dIn = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      repeat (20) @(negedge clk);
      check_eq(tag, q.size(), 0);
      q.delete();
   endtask

   // Monitor: every pulse must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (resetN) begin
            if (keyValid | parityErr | frameErr) begin
               check_eq("onehot", $countones({keyValid, parityErr, frameErr}), 1);
               check_eq("pulse_width", {31'd0, prev_any}, 0);
               check_eq("ev_pending", {31'd0, q.size() != 0}, 1);
               if (q.size() != 0) begin
                  ev_t e;
                  int  k;
                  e = q.pop_front();
                  k = keyValid ? EV_VALID : (parityErr ? EV_PARITY : EV_FRAME);
                  check_eq("ev_kind", k, e.kind);
                  check_eq("keyCode", {24'd0, keyCode}, {24'd0, e.code});
                  check_eq("keyExt", {31'd0, keyExt}, {31'd0, e.ext});
                  check_eq("keyBreak", {31'd0, keyBreak}, {31'd0, e.brk});
                  if (e.at != 0) check_eq("tmo_cycle", cyc, e.at);
               end
            end
            prev_any = keyValid | parityErr | frameErr;
         end else begin
            prev_any = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check_eq("rst_keyCode", {24'd0, keyCode}, 0);
      check_eq("rst_keyExt", {31'd0, keyExt}, 0);
      check_eq("rst_keyBreak", {31'd0, keyBreak}, 0);
      check_eq("rst_keyValid", {31'd0, keyValid}, 0);
      check_eq("rst_parityErr", {31'd0, parityErr}, 0);
      check_eq("rst_frameErr", {31'd0, frameErr}, 0);

      // Clock fall with data high while idle is ignored
      ps2_bit(1'b1);
      drain("idle_noise");

      send_frame(8'h1C, 1'b0, 1'b0);
      drain("make_1C");

      send_frame(8'hF0, 1'b0, 1'b0);
      drain("prefix_F0");
      send_frame(8'h1C, 1'b0, 1'b0);
      drain("break_1C");

      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      drain("ext_break_75");
      send_frame(8'h29, 1'b0, 1'b0);
      drain("plain_29");

      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      drain("parity_err");
      send_frame(8'h1C, 1'b0, 1'b0);
      drain("after_parity");

      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h33, 1'b0, 1'b1);
      drain("stop_err");
      send_frame(8'h1C, 1'b0, 1'b0);
      drain("after_stop");

      // Partial frame abandoned by the inter-edge timeout
      send_frame(8'hE0, 1'b0, 1'b0);
      begin
         logic [7:0] pb;
         pb = 8'h1C;
         ps2_bit(1'b0);
         for (int i = 0; i < 5; i++) ps2_bit(pb[i]);
      end
      push_ev(EV_FRAME, t_fall + 3 + TMO);
      m_ext = 1'b0; m_brk = 1'b0;
      repeat (TMO + 20) @(negedge clk);
      drain("timeout");
      send_frame(8'h1C, 1'b0, 1'b0);
      drain("after_timeout");

      // Reset in the middle of a frame drops it silently
      begin
         logic [7:0] pb;
         pb = 8'h5A;
         ps2_bit(1'b0);
         for (int i = 0; i < 4; i++) ps2_bit(pb[i]);
      end
      @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0;
      m_code = 8'h00; m_kext = 1'b0; m_kbrk = 1'b0;
      @(negedge clk);
      check_eq("midrst_keyCode", {24'd0, keyCode}, 0);
      check_eq("midrst_keyExt", {31'd0, keyExt}, 0);
      check_eq("midrst_keyBreak", {31'd0, keyBreak}, 0);
      repeat (50) @(negedge clk);
      check_eq("midrst_nopulse", q.size(), 0);
      send_frame(8'h5A, 1'b0, 1'b0);
      drain("after_reset_5A");
      check_eq("final_keyCode", {24'd0, keyCode}, 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
